// File: rtl/data_sram_if.sv
// Bus between the pipeline memory stage (master) and the data RAM/MMIO responder (slave).
interface data_sram_if;
    logic        en;
    logic [3:0]  we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;

    modport master (output en, we, addr, wdata, input rdata);
    modport slave  (input en, we, addr, wdata, output rdata);
endinterface

// File: rtl/data_sram_responder.sv
// Byte-writable synchronous data RAM plus a small MMIO window (cycle counter, tohost, LEDs).
// Both regions answer with one cycle of read latency through a shared registered mux.
module data_sram_responder #(
    parameter int         DEPTH_LOG2 = 10,
    parameter logic [3:0] MMIO_TAG   = 4'hF
) (
    input  logic        clk,
    input  logic        resetn,
    data_sram_if.slave  bus,
    output logic [15:0] led_o,
    output logic        done_o,
    output logic [31:0] tohost_o
);

    localparam int DEPTH = 1 << DEPTH_LOG2;

    logic [31:0]           mem [DEPTH];
    logic [DEPTH_LOG2-1:0] ram_index;
    logic [5:0]            mmio_word;
    logic                  is_mmio;
    logic                  is_write;
    logic                  ram_access;
    logic                  mmio_access;
    logic                  cycle_write;
    logic                  tohost_write;
    logic                  led_write;
    logic [31:0]           cycle_count;
    logic [31:0]           tohost_next;
    logic [31:0]           mmio_read;
    logic [31:0]           ram_q;
    logic [31:0]           mmio_q;
    logic                  sel_mmio_q;

    function automatic logic [31:0] merge_lanes(input logic [31:0] old_word,
                                                input logic [31:0] new_word,
                                                input logic [3:0]  lanes);
        logic [31:0] merged;
        merged = old_word;
        for (int i = 0; i < 4; i++) begin
            if (lanes[i]) merged[8*i +: 8] = new_word[8*i +: 8];
        end
        return merged;
    endfunction

    // Upper address bits above the RAM index simply alias onto the same words.
    assign ram_index    = bus.addr[DEPTH_LOG2+1:2];
    assign mmio_word    = bus.addr[7:2];
    assign is_mmio      = (bus.addr[31:28] == MMIO_TAG);
    assign is_write     = (bus.we != 4'b0000);
    assign ram_access   = bus.en && !is_mmio;
    assign mmio_access  = bus.en && is_mmio;
    assign cycle_write  = mmio_access && is_write && (mmio_word == 6'h00);
    assign tohost_write = mmio_access && is_write && (mmio_word == 6'h01);
    assign led_write    = mmio_access && is_write && (mmio_word == 6'h02);
    assign tohost_next  = merge_lanes(tohost_o, bus.wdata, bus.we);

    always_comb begin
        mmio_read = '0;
        case (mmio_word)
            6'h00:   mmio_read = cycle_count;
            6'h01:   mmio_read = tohost_o;
            6'h02:   mmio_read = {16'h0000, led_o};
            default: mmio_read = '0;
        endcase
    end

    // RAM port: the old word is captured on every access, giving read-before-write.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            ram_q <= '0;
        end else if (ram_access) begin
            ram_q <= mem[ram_index];
            for (int i = 0; i < 4; i++) begin
                if (bus.we[i]) mem[ram_index][8*i +: 8] <= bus.wdata[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            cycle_count <= '0;
            tohost_o    <= '0;
            done_o      <= 1'b0;
            led_o       <= '0;
        end else begin
            if (cycle_write) cycle_count <= merge_lanes(cycle_count, bus.wdata, bus.we);
            else             cycle_count <= cycle_count + 32'd1;
            if (tohost_write) begin
                tohost_o <= tohost_next;
                if (tohost_next != 32'd0) done_o <= 1'b1;
            end
            if (led_write && bus.we[0]) led_o[7:0]  <= bus.wdata[7:0];
            if (led_write && bus.we[1]) led_o[15:8] <= bus.wdata[15:8];
        end
    end

    // The region select travels with the request so rdata holds across idle cycles.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            mmio_q     <= '0;
            sel_mmio_q <= 1'b0;
        end else if (mmio_access) begin
            mmio_q     <= mmio_read;
            sel_mmio_q <= 1'b1;
        end else if (ram_access) begin
            sel_mmio_q <= 1'b0;
        end
    end

    assign bus.rdata = sel_mmio_q ? mmio_q : ram_q;

endmodule

// File: tb/tb_data_sram_responder.sv
// Directed self-checking bench for data_sram_responder.
module tb_data_sram_responder;

    logic        clk;
    logic        resetn;
    logic [15:0] led_o;
    logic        done_o;
    logic [31:0] tohost_o;
    int          checks;
    int          failures;

    data_sram_if bus ();

    data_sram_responder #(.DEPTH_LOG2(10), .MMIO_TAG(4'hF)) dut (
        .clk      (clk),
        .resetn   (resetn),
        .bus      (bus),
        .led_o    (led_o),
        .done_o   (done_o),
        .tohost_o (tohost_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One request per call: drive at the falling edge, let one rising edge pass, return at the next fall.
    task automatic applyStimulus(input logic en, input logic [3:0] we,
                                 input logic [31:0] addr, input logic [31:0] wdata);
        bus.en    = en;
        bus.we    = we;
        bus.addr  = addr;
        bus.wdata = wdata;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        resetn   = 1'b0;
        bus.en   = 1'b0;
        bus.we   = 4'h0;
        bus.addr = '0;
        bus.wdata = '0;
        @(negedge clk);
        applyStimulus(1'b0, 4'h0, 32'h0, 32'h0);
        applyStimulus(1'b0, 4'h0, 32'h0, 32'h0);

        resetn = 1'b1;
        for (int i = 0; i < 5; i++) applyStimulus(1'b0, 4'h0, 32'h0, 32'h0);
        applyStimulus(1'b1, 4'h0, 32'hF000_0000, 32'h0);
        checkOutput("cycle_after_5", bus.rdata, 32'd5);
        applyStimulus(1'b0, 4'h0, 32'h0, 32'h0);
        applyStimulus(1'b0, 4'h0, 32'h0, 32'h0);
        checkOutput("idle_hold", bus.rdata, 32'd5);

        applyStimulus(1'b1, 4'hF, 32'h0000_0200, 32'hCAFE_F00D);
        resetn = 1'b0;
        applyStimulus(1'b1, 4'hF, 32'h0000_0200, 32'h0BAD_BAD0);
        applyStimulus(1'b1, 4'hF, 32'hF000_0004, 32'h0000_0077);
        checkOutput("reset_rdata", bus.rdata, 32'h0);
        checkOutput("reset_done", {31'h0, done_o}, 32'h0);
        checkOutput("reset_tohost", tohost_o, 32'h0);
        resetn = 1'b1;
        applyStimulus(1'b1, 4'h0, 32'h0000_0200, 32'h0);
        checkOutput("ram_kept_write_dropped", bus.rdata, 32'hCAFE_F00D);

        applyStimulus(1'b1, 4'hF, 32'h0000_0100, 32'hDEAD_BEEF);
        applyStimulus(1'b1, 4'h0, 32'h0000_0100, 32'h0);
        checkOutput("word_rw", bus.rdata, 32'hDEAD_BEEF);
        applyStimulus(1'b1, 4'h4, 32'h0000_0102, 32'h00AA_0000);
        applyStimulus(1'b1, 4'h0, 32'h0000_0100, 32'h0);
        checkOutput("byte_write", bus.rdata, 32'hDEAA_BEEF);
        applyStimulus(1'b1, 4'h3, 32'h0000_0100, 32'h0000_1234);
        applyStimulus(1'b1, 4'h0, 32'h0000_0100, 32'h0);
        checkOutput("half_write", bus.rdata, 32'hDEAA_1234);

        applyStimulus(1'b1, 4'hF, 32'h0000_0104, 32'h2222_2222);
        applyStimulus(1'b1, 4'hF, 32'h0000_0104, 32'h1111_1111);
        checkOutput("read_before_write", bus.rdata, 32'h2222_2222);
        applyStimulus(1'b1, 4'h0, 32'h0000_0104, 32'h0);
        checkOutput("after_rbw", bus.rdata, 32'h1111_1111);

        applyStimulus(1'b1, 4'hF, 32'h0000_1000, 32'h1357_9BDF);
        applyStimulus(1'b1, 4'h0, 32'h0000_0000, 32'h0);
        checkOutput("alias", bus.rdata, 32'h1357_9BDF);

        applyStimulus(1'b1, 4'hF, 32'hF000_0000, 32'hFFFF_FFFE);
        applyStimulus(1'b1, 4'h0, 32'hF000_0000, 32'h0);
        checkOutput("cycle_loaded", bus.rdata, 32'hFFFF_FFFE);
        applyStimulus(1'b1, 4'h0, 32'hF000_0000, 32'h0);
        checkOutput("cycle_max", bus.rdata, 32'hFFFF_FFFF);
        applyStimulus(1'b1, 4'h0, 32'hF000_0000, 32'h0);
        checkOutput("cycle_wrap", bus.rdata, 32'h0);
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 4'h0, 32'hF000_0000, 32'h0);
        checkOutput("wrap_hold", bus.rdata, 32'h0);

        applyStimulus(1'b1, 4'hF, 32'hF000_0004, 32'h0);
        checkOutput("tohost_zero_done", {31'h0, done_o}, 32'h0);
        applyStimulus(1'b1, 4'hF, 32'hF000_0004, 32'h1);
        checkOutput("tohost_one_done", {31'h0, done_o}, 32'h1);
        checkOutput("tohost_one_val", tohost_o, 32'h1);
        applyStimulus(1'b1, 4'h0, 32'hF000_0004, 32'h0);
        checkOutput("tohost_read", bus.rdata, 32'h1);
        applyStimulus(1'b1, 4'hF, 32'hF000_0004, 32'h0);
        checkOutput("done_sticky", {31'h0, done_o}, 32'h1);
        checkOutput("tohost_cleared", tohost_o, 32'h0);

        applyStimulus(1'b1, 4'hF, 32'hF000_0008, 32'hFFFF_5A5A);
        checkOutput("led_out", {16'h0, led_o}, 32'h0000_5A5A);
        applyStimulus(1'b1, 4'h0, 32'hF000_0008, 32'h0);
        checkOutput("led_read", bus.rdata, 32'h0000_5A5A);
        applyStimulus(1'b1, 4'h0, 32'hF000_0010, 32'h0);
        checkOutput("unmapped_read", bus.rdata, 32'h0);

        applyStimulus(1'b1, 4'hF, 32'hF000_0004, 32'h0000_00A5);
        resetn = 1'b0;
        applyStimulus(1'b0, 4'h0, 32'h0, 32'h0);
        checkOutput("final_reset_done", {31'h0, done_o}, 32'h0);
        checkOutput("final_reset_tohost", tohost_o, 32'h0);
        checkOutput("final_reset_led", {16'h0, led_o}, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
